// File: rtl/id_ex_reg.sv
// -----------------------------------------------------------------------------
// id_ex_reg -- ID/EX pipeline register for a classic 5-stage MIPS-style core.
//
// Captures the decoded instruction (PC+4, operand data, immediate, register
// numbers and control bits) at the end of ID and presents it to EX one cycle
// later. Every ex_* output comes straight from a flop.
//
// Ports
//   clk, reset           rising-edge clock, synchronous active-high reset
//   stall                hold the current EX slot unchanged
//   flush                replace the EX slot with an all-zero bubble
//   id_pc4/rd1/rd2/imm   DATA_W-bit data fields from ID
//   id_rs/rt/rd          5-bit register numbers from the instruction word
//   id_<ctrl>, id_alu_op control bits from the decoder
//   ex_*                 registered copies of every id_* field
//   ex_valid             EX slot holds a real instruction (0 for a bubble)
//   load_use             combinational load-use hazard request to IF/ID
//
// Update priority on each rising edge: reset > flush > stall > load.
// The block only reports load_use; the hazard controller decides what to do.
// -----------------------------------------------------------------------------
module id_ex_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic              id_reg_dst,
  input  logic              id_alu_src,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              id_reg_write,
  input  logic              id_branch,
  input  logic [1:0]        id_alu_op,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic              ex_reg_dst,
  output logic              ex_alu_src,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic              ex_reg_write,
  output logic              ex_branch,
  output logic [1:0]        ex_alu_op,
  output logic              ex_valid,
  output logic              load_use
);

  // One EX slot; bundling the fields keeps reset/flush/load uniform.
  typedef struct packed {
    logic [DATA_W-1:0] pc4;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic              reg_dst;
    logic              alu_src;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic              reg_write;
    logic              branch;
    logic [1:0]        alu_op;
  } slot_t;

  slot_t w_id_slot;
  slot_t r_slot;
  logic  r_valid;
  logic  w_rt_match;
  logic  w_load_use;

  assign w_id_slot = '{
    pc4:        id_pc4,
    rd1:        id_rd1,
    rd2:        id_rd2,
    imm:        id_imm,
    rs:         id_rs,
    rt:         id_rt,
    rd:         id_rd,
    reg_dst:    id_reg_dst,
    alu_src:    id_alu_src,
    mem_read:   id_mem_read,
    mem_write:  id_mem_write,
    mem_to_reg: id_mem_to_reg,
    reg_write:  id_reg_write,
    branch:     id_branch,
    alu_op:     id_alu_op
  };

  // EX slot register: reset and flush both produce a fully zeroed bubble, so
  // a bubble can never write the register file or touch memory.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_slot  <= '0;
      r_valid <= 1'b0;
    end else if (flush) begin
      r_slot  <= '0;
      r_valid <= 1'b0;
    end else if (!stall) begin
      r_slot  <= w_id_slot;
      r_valid <= 1'b1;
    end
  end

  // Load-use detection against the live ID register numbers. $zero never
  // creates a hazard; reset masks the request so that a stale lw held in the
  // slot cannot raise it before the first reset edge has cleared the slot.
  always_comb begin
    w_rt_match = 1'b0;
    w_load_use = 1'b0;
    if ((r_slot.rt == id_rs) || (r_slot.rt == id_rt)) begin
      w_rt_match = 1'b1;
    end else begin
      w_rt_match = 1'b0;
    end
    if (!reset && r_valid && r_slot.mem_read && (r_slot.rt != 5'd0) && w_rt_match) begin
      w_load_use = 1'b1;
    end else begin
      w_load_use = 1'b0;
    end
  end

  assign load_use      = w_load_use;
  assign ex_pc4        = r_slot.pc4;
  assign ex_rd1        = r_slot.rd1;
  assign ex_rd2        = r_slot.rd2;
  assign ex_imm        = r_slot.imm;
  assign ex_rs         = r_slot.rs;
  assign ex_rt         = r_slot.rt;
  assign ex_rd         = r_slot.rd;
  assign ex_reg_dst    = r_slot.reg_dst;
  assign ex_alu_src    = r_slot.alu_src;
  assign ex_mem_read   = r_slot.mem_read;
  assign ex_mem_write  = r_slot.mem_write;
  assign ex_mem_to_reg = r_slot.mem_to_reg;
  assign ex_reg_write  = r_slot.reg_write;
  assign ex_branch     = r_slot.branch;
  assign ex_alu_op     = r_slot.alu_op;
  assign ex_valid      = r_valid;

endmodule

// File: tb/tb_id_ex_reg.sv
// -----------------------------------------------------------------------------
// tb_id_ex_reg -- self-checking bench for id_ex_reg.
// The reference model is a single "EX slot" variable updated by the
// reset > flush > stall > load rule on each edge; load_use is recomputed from
// that slot and the live ID register numbers.
// -----------------------------------------------------------------------------
module tb_id_ex_reg;

  localparam int DW = 32;

  typedef struct packed {
    logic [DW-1:0] pc4;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic [DW-1:0] imm;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    rd;
    logic          reg_dst;
    logic          alu_src;
    logic          mem_read;
    logic          mem_write;
    logic          mem_to_reg;
    logic          reg_write;
    logic          branch;
    logic [1:0]    alu_op;
  } fields_t;

  logic    clk = 1'b0;
  logic    reset, stall, flush;
  fields_t in_f;
  fields_t obs_f;
  logic    ex_valid, load_use;

  fields_t exp_f;
  logic    exp_v;
  fields_t q_f[$];

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  id_ex_reg #(.DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .id_pc4(in_f.pc4), .id_rd1(in_f.rd1), .id_rd2(in_f.rd2), .id_imm(in_f.imm),
    .id_rs(in_f.rs), .id_rt(in_f.rt), .id_rd(in_f.rd),
    .id_reg_dst(in_f.reg_dst), .id_alu_src(in_f.alu_src),
    .id_mem_read(in_f.mem_read), .id_mem_write(in_f.mem_write),
    .id_mem_to_reg(in_f.mem_to_reg), .id_reg_write(in_f.reg_write),
    .id_branch(in_f.branch), .id_alu_op(in_f.alu_op),
    .ex_pc4(obs_f.pc4), .ex_rd1(obs_f.rd1), .ex_rd2(obs_f.rd2), .ex_imm(obs_f.imm),
    .ex_rs(obs_f.rs), .ex_rt(obs_f.rt), .ex_rd(obs_f.rd),
    .ex_reg_dst(obs_f.reg_dst), .ex_alu_src(obs_f.alu_src),
    .ex_mem_read(obs_f.mem_read), .ex_mem_write(obs_f.mem_write),
    .ex_mem_to_reg(obs_f.mem_to_reg), .ex_reg_write(obs_f.reg_write),
    .ex_branch(obs_f.branch), .ex_alu_op(obs_f.alu_op),
    .ex_valid(ex_valid), .load_use(load_use)
  );

  function automatic fields_t rand_fields();
    fields_t f;
    f.pc4 = $urandom(); f.rd1 = $urandom(); f.rd2 = $urandom(); f.imm = $urandom();
    f.rs = 5'($urandom_range(0, 31)); f.rt = 5'($urandom_range(0, 31));
    f.rd = 5'($urandom_range(0, 31));
    f.reg_dst = 1'($urandom()); f.alu_src = 1'($urandom()); f.mem_read = 1'($urandom());
    f.mem_write = 1'($urandom()); f.mem_to_reg = 1'($urandom());
    f.reg_write = 1'($urandom()); f.branch = 1'($urandom()); f.alu_op = 2'($urandom());
    return f;
  endfunction

  // Hazard rule: a valid load in EX whose destination (non-$zero) is read in ID.
  function automatic logic model_lu();
    if (reset) return 1'b0;
    return exp_v && exp_f.mem_read && (exp_f.rt != 5'd0) &&
           ((exp_f.rt == in_f.rs) || (exp_f.rt == in_f.rt));
  endfunction

  task automatic chk_slot(input string tag);
    vectors++;
    assert (obs_f === exp_f) else begin
      errors++;
      $error("FAIL %s fields obs=%h exp=%h", tag, obs_f, exp_f);
    end
    vectors++;
    assert (ex_valid === exp_v) else begin
      errors++;
      $error("FAIL %s ex_valid obs=%b exp=%b", tag, ex_valid, exp_v);
    end
  endtask

  task automatic chk_lu(input string tag);
    logic e;
    e = model_lu();
    vectors++;
    assert (load_use === e) else begin
      errors++;
      $error("FAIL %s load_use obs=%b exp=%b", tag, load_use, e);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // One rising edge: update the model with the inputs seen at the edge, then check.
  task automatic tick(input string tag);
    @(posedge clk);
    if (reset) begin
      exp_f = '0; exp_v = 1'b0;
    end else if (flush) begin
      exp_f = '0; exp_v = 1'b0;
    end else if (!stall) begin
      exp_f = in_f; exp_v = 1'b1;
    end
    #1;
    chk_slot(tag);
    chk_lu(tag);
  endtask

  initial begin
    fields_t a, b;
    reset = 1'b1; stall = 1'b0; flush = 1'b0; in_f = rand_fields();
    exp_f = '0; exp_v = 1'b0;

    // Reset state
    tick("reset0");
    tick("reset1");
    reset = 1'b0;

    // Directed load
    in_f = '0; in_f.rd1 = 32'h0000_1234; in_f.rt = 5'd5; in_f.rd = 5'd9; in_f.reg_write = 1'b1;
    tick("load");
    chk_word("load_rd1", obs_f.rd1, 32'h0000_1234);
    chk_word("load_rt", {27'd0, obs_f.rt}, 32'd5);
    chk_word("load_rd", {27'd0, obs_f.rd}, 32'd9);
    chk_bit("load_reg_write", obs_f.reg_write, 1'b1);
    chk_bit("load_valid", ex_valid, 1'b1);

    // Stall holds A for three edges, then B loads
    a = rand_fields(); a.rt = 5'd7; a.mem_read = 1'b1; in_f = a;
    tick("stall_loadA");
    b = rand_fields(); b.rt = 5'd12; in_f = b; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick("stall_hold");
      chk_word("stall_holdA_rd1", obs_f.rd1, a.rd1);
    end
    stall = 1'b0;
    tick("stall_release");
    chk_word("stall_B_pc4", obs_f.pc4, b.pc4);

    // Flush wins over stall
    stall = 1'b1; flush = 1'b1;
    tick("flush_stall");
    chk_bit("bubble_valid", ex_valid, 1'b0);
    chk_bit("bubble_ctrl", |{obs_f.reg_write, obs_f.mem_write, obs_f.mem_read,
                             obs_f.reg_dst, obs_f.alu_src, obs_f.mem_to_reg,
                             obs_f.branch, obs_f.alu_op}, 1'b0);
    chk_word("bubble_rd1", obs_f.rd1, 32'd0);
    stall = 1'b0; flush = 1'b0;

    // Load-use
    in_f = rand_fields(); in_f.rt = 5'd8; in_f.mem_read = 1'b1;
    tick("lu_lw8");
    in_f.rs = 5'd8; in_f.rt = 5'd3; #1;
    chk_lu("lu_rs_match");
    chk_bit("lu_rs_match_const", load_use, 1'b1);
    in_f.rs = 5'd3; in_f.rt = 5'd3; #1;
    chk_bit("lu_no_match", load_use, 1'b0);
    in_f.rt = 5'd0; in_f.mem_read = 1'b1; in_f.rs = 5'd0;
    tick("lu_lw0");
    chk_bit("lu_zero", load_use, 1'b0);

    // Reset while stalled on a valid lw
    in_f = rand_fields(); in_f.rt = 5'd8; in_f.mem_read = 1'b1;
    tick("rst_lw");
    stall = 1'b1; in_f.rs = 5'd8; #1;
    chk_bit("rst_pre_lu", load_use, 1'b1);
    reset = 1'b1; #1;
    chk_bit("rst_held_lu", load_use, 1'b0);
    tick("rst_edge");
    chk_bit("rst_valid", ex_valid, 1'b0);
    reset = 1'b0; stall = 1'b0; in_f = rand_fields();
    tick("rst_release");
    chk_word("rst_release_imm", obs_f.imm, in_f.imm);

    // Back-to-back stream, compared against an in-order queue
    for (int i = 0; i < 4; i++) begin
      in_f = rand_fields(); in_f.pc4 = 32'h100 + 32'(4 * i);
      q_f.push_back(in_f);
      tick("b2b");
      vectors++;
      assert (obs_f === q_f[0]) else begin
        errors++;
        $error("FAIL b2b_order obs=%h exp=%h", obs_f.pc4, q_f[0].pc4);
      end
      void'(q_f.pop_front());
    end

    // Random control mix with small register numbers to provoke hazards
    for (int i = 0; i < 300; i++) begin
      in_f = rand_fields();
      in_f.rs = 5'($urandom_range(0, 3)); in_f.rt = 5'($urandom_range(0, 3));
      reset = ($urandom_range(0, 19) == 0);
      flush = ($urandom_range(0, 5) == 0);
      stall = ($urandom_range(0, 2) == 0);
      #1;
      chk_lu("rand_pre");
      tick("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
- REQ-001: The block SHALL have parameter DATA_W, default 32, giving the width of the PC, register-data and immediate fields.
- REQ-002: The block SHALL use one clock and a synchronous, active-high reset, with ports as follows.
  - clk  in  1  rising-edge clock
  - reset  in  1  synchronous, active-high reset
- REQ-003: The stall and flush control ports SHALL be:
  - stall  in  1  hold all registers
  - flush  in  1  insert bubble
- REQ-004: The ID-stage data inputs SHALL be:
  - id_pc4  in  DATA_W  PC+4
  - id_rd1  in  DATA_W  rs read data
  - id_rd2  in  DATA_W  rt read data
  - id_imm  in  DATA_W  sign-extended immediate
- REQ-005: The ID-stage register-number inputs SHALL be:
  - id_rs  in  5  instr[25:21]
  - id_rt  in  5  instr[20:16]
  - id_rd  in  5  instr[15:11]
- REQ-006: The ID-stage control inputs SHALL be:
  - id_reg_dst, id_alu_src, id_mem_read, id_mem_write, id_mem_to_reg, id_reg_write, id_branch  in  1 each  control bits
  - id_alu_op  in  2  ALU operation class
- REQ-007: The block SHALL have outputs ex_<field> for every registered input above, each of the same width as its input.
- REQ-008: The block SHALL have output ex_valid  out  1  EX slot holds a real instruction.
- REQ-009: The block SHALL have output load_use  out  1  combinational load-use hazard request to the IF/ID stage.

Function
- REQ-010: All ex_* outputs SHALL be driven directly from flops, with no combinational path from id_* to ex_*.
- REQ-011: Latency SHALL be 1 cycle: id_* values sampled at edge N SHALL appear on ex_* after edge N.
- REQ-012: Priority per rising edge SHALL be reset > flush > stall > load.
- REQ-013: Load (stall=0, flush=0): every field SHALL capture its id_* input, and ex_valid SHALL become 1.
- REQ-014: Stall (stall=1, flush=0): every register, ex_valid included, SHALL hold its value.
- REQ-015: Flush (flush=1) SHALL clear all control outputs (reg_dst, alu_src, alu_op, mem_read, mem_write, mem_to_reg, reg_write, branch) and ex_valid to 0.
- REQ-016: On flush, data and register-number fields SHALL also be cleared to 0, so a bubble is fully deterministic.
- REQ-017: Flush together with stall in the same cycle SHALL produce a bubble; stall SHALL be ignored.
- REQ-018: A bubble SHALL never assert ex_reg_write, ex_mem_write or ex_mem_read.
- REQ-019: ex_rt and ex_rd SHALL be delivered unchanged, each exactly 5 bits, to the EX destination-register select.
- REQ-020: The block SHALL NOT perform the rt/rd selection itself; ex_reg_dst SHALL be passed through for that purpose.
- REQ-021: load_use SHALL equal ex_valid & ex_mem_read & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt)).
- REQ-022: load_use SHALL be purely combinational, computed from the current register contents and the live id_rs/id_rt.
- REQ-023: load_use SHALL be 0 whenever ex_rt == 0, since $zero never creates a hazard.
- REQ-024: The block SHALL NOT act on its own load_use output; the external controller is responsible for driving stall/flush in response.

Reset
- REQ-025: When reset=1 at a rising edge, all ex_* outputs, including ex_valid, SHALL become 0 on that edge.
- REQ-026: Reset SHALL take effect regardless of stall or flush.
- REQ-027: While reset is held, load_use SHALL be 0.
- REQ-028: Reset asserted mid-stall SHALL discard the held instruction; the first edge with reset=0 SHALL load normally.

Verification
- REQ-029: Load test: apply id_rd1=0x0000_1234, id_rt=5, id_rd=9, id_reg_write=1, one edge, stall=flush=0 -> ex_rd1=0x0000_1234, ex_rt=5, ex_rd=9, ex_reg_write=1, ex_valid=1.
- REQ-030: Stall test: load instruction A, then change the id_* inputs to B with stall=1 for 3 edges -> ex_* hold A for all 3 cycles; drop stall -> B appears after the next edge.
- REQ-031: Flush-over-stall test: with A held, assert stall=1 and flush=1 on the same edge -> ex_valid=0, all control outputs 0, ex_rt=0, ex_rd1=0.
- REQ-032: Load-use test: load lw with ex_rt=8 and mem_read=1, then drive id_rs=8 -> load_use=1; with id_rs=id_rt=3 -> load_use=0; lw with ex_rt=0 and id_rs=0 -> load_use=0.
- REQ-033: Reset test: assert reset with stall=1 while holding a valid lw -> all outputs 0 and load_use=0 after the edge; release reset -> the next edge loads the current id_* inputs.
- REQ-034: Back-to-back test: stream 4 distinct instructions, one per cycle, with no stall -> each appears on ex_* exactly 1 cycle after it is presented, in order, with none dropped or duplicated.
